dm_cache_ctrl: RTL and testbench

//  Direct-mapped, write-through, no-write-allocate cache controller that drives the tag RAM and the line data RAM.

---
 rtl/dm_cache_ctrl_pkg.sv | 18 +
 rtl/dm_cache_ctrl.sv | 127 ++++++++++++
 tb/tb_dm_cache_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_cache_ctrl_pkg.sv
// dm_cache_ctrl_pkg: shared cache geometry and FSM encoding for the direct-mapped cache controller
package dm_cache_ctrl_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LINE_WORDS = 4;
    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int OFF_W = WORD_W + 2;
    localparam int INDEX_LENGTH = 6;
    localparam int CACHE_LINE_NUM = 1 << INDEX_LENGTH;
    localparam int TAG_LENGTH = ADDR_W - INDEX_LENGTH - OFF_W;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        REFILL = 3'd2,
        RESP   = 3'd3,
        WMEM   = 3'd4
    } cacheState_t;
endpackage

// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: direct-mapped write-through, no-write-allocate cache controller
// driving external tag/data RAMs and a word-at-a-time memory bus.
module dm_cache_ctrl
    import dm_cache_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [ADDR_W-1:0]       cpu_addr,
    input  logic [DATA_W-1:0]       cpu_wdata,
    output logic                    cpu_ready,
    output logic [DATA_W-1:0]       cpu_rdata,
    output logic [INDEX_LENGTH-1:0] tag_index,
    output logic [TAG_LENGTH-1:0]   tag_in,
    output logic                    tag_w_en,
    input  logic [TAG_LENGTH-1:0]   tag_out,
    output logic [INDEX_LENGTH-1:0] data_index,
    output logic [WORD_W-1:0]       data_word,
    output logic                    data_w_en,
    output logic [DATA_W-1:0]       data_wdata,
    input  logic [DATA_W-1:0]       data_rdata,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic [DATA_W-1:0]       mem_rdata,
    input  logic                    mem_ack
);
    cacheState_t state, nextState;
    logic [ADDR_W-1:0] reqAddr;
    logic reqWe;
    logic [DATA_W-1:0] reqWdata;
    logic [WORD_W-1:0] cnt;
    logic [CACHE_LINE_NUM-1:0] validBits;
    logic [TAG_LENGTH-1:0] reqTag;
    logic [INDEX_LENGTH-1:0] reqIdx;
    logic [WORD_W-1:0] reqWord;
    logic hit, lastAck;

    assign reqTag = reqAddr[ADDR_W-1 -: TAG_LENGTH];
    assign reqIdx = reqAddr[OFF_W +: INDEX_LENGTH];
    assign reqWord = reqAddr[2 +: WORD_W];
    assign hit = validBits[reqIdx] && (tag_out == reqTag);
    assign lastAck = (state == REFILL) && mem_ack && (cnt == WORD_W'(LINE_WORDS - 1));
    assign tag_index = reqIdx;
    assign data_index = reqIdx;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= nextState;

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = cpu_req ? LOOKUP : IDLE;
            LOOKUP:  nextState = reqWe ? WMEM : (hit ? IDLE : REFILL);
            REFILL:  nextState = lastAck ? RESP : REFILL;
            RESP:    nextState = IDLE;
            WMEM:    nextState = mem_ack ? IDLE : WMEM;
            default: nextState = IDLE;
        endcase
    end

    // The counter parks on the last word after the final ack and only clears on leaving RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reqAddr <= '0;
            reqWe <= 1'b0;
            reqWdata <= '0;
            cnt <= '0;
            validBits <= '0;
        end else begin
            if (state == IDLE && cpu_req) begin
                reqAddr <= cpu_addr;
                reqWe <= cpu_we;
                reqWdata <= cpu_wdata;
            end
            if (state == LOOKUP || state == RESP) cnt <= '0;
            else if (state == REFILL && mem_ack && !lastAck) cnt <= cnt + 1'b1;
            if (lastAck) validBits[reqIdx] <= 1'b1;
        end
    end

    always_comb begin
        cpu_ready = 1'b0;
        cpu_rdata = '0;
        tag_in = '0;
        tag_w_en = 1'b0;
        data_word = reqWord;
        data_w_en = 1'b0;
        data_wdata = '0;
        mem_req = 1'b0;
        mem_we = 1'b0;
        mem_addr = '0;
        mem_wdata = '0;
        case (state)
            LOOKUP: begin
                cpu_ready = !reqWe && hit;
                cpu_rdata = cpu_ready ? data_rdata : '0;
                data_w_en = reqWe && hit;
                data_wdata = reqWe ? reqWdata : '0;
            end
            REFILL: begin
                mem_req = 1'b1;
                mem_addr = {reqTag, reqIdx, cnt, 2'b00};
                data_word = cnt;
                data_w_en = mem_ack;
                data_wdata = mem_ack ? mem_rdata : '0;
                tag_w_en = lastAck;
                tag_in = reqTag;
            end
            RESP: begin
                cpu_ready = 1'b1;
                cpu_rdata = data_rdata;
            end
            WMEM: begin
                mem_req = 1'b1;
                mem_we = 1'b1;
                mem_addr = reqAddr;
                mem_wdata = reqWdata;
                cpu_ready = mem_ack;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb_dm_cache_ctrl: randomized self-checking bench; tag/data RAMs and memory are bench models,
// expectations come from a line-presence map and a flat word memory.
module tb_dm_cache_ctrl;
    import dm_cache_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cpu_req, cpu_we, cpu_ready;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic [INDEX_LENGTH-1:0] tag_index, data_index;
    logic [TAG_LENGTH-1:0] tag_in, tag_out;
    logic tag_w_en, data_w_en;
    logic [WORD_W-1:0] data_word;
    logic [DATA_W-1:0] data_wdata, data_rdata;
    logic mem_req, mem_we, mem_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    dm_cache_ctrl dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .tag_index(tag_index), .tag_in(tag_in), .tag_w_en(tag_w_en), .tag_out(tag_out),
        .data_index(data_index), .data_word(data_word), .data_w_en(data_w_en),
        .data_wdata(data_wdata), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    // Tag RAM starts at all-zero so a tag-0 access at index 0 matches the stored tag before any fill.
    logic [TAG_LENGTH-1:0] tagRam [CACHE_LINE_NUM] = '{default: '0};
    logic [DATA_W-1:0] dataRam [CACHE_LINE_NUM][LINE_WORDS] = '{default: '{default: 32'h0BAD_F00D}};
    assign tag_out = tagRam[tag_index];
    assign data_rdata = dataRam[data_index][data_word];
    always @(posedge clk) begin
        if (tag_w_en) tagRam[tag_index] <= tag_in;
        if (data_w_en) dataRam[data_index][data_word] <= data_wdata;
    end

    int nChecks = 0;
    int nFails = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] memInit(input logic [ADDR_W-1:0] a);
        return a * 32'h9E37_79B1 ^ 32'h5A5A_1234;
    endfunction

    // External memory as seen by the DUT, and the reference view of what it should hold.
    logic [DATA_W-1:0] extMem [logic [ADDR_W-1:0]];
    logic [DATA_W-1:0] refMem [logic [ADDR_W-1:0]];
    bit mVal [CACHE_LINE_NUM];
    logic [TAG_LENGTH-1:0] mTag [CACHE_LINE_NUM];

    function automatic logic [DATA_W-1:0] extRd(input logic [ADDR_W-1:0] a);
        return extMem.exists(a) ? extMem[a] : memInit(a);
    endfunction

    function automatic logic [DATA_W-1:0] refRd(input logic [ADDR_W-1:0] a);
        return refMem.exists(a) ? refMem[a] : memInit(a);
    endfunction

    // Memory responder: each word is acked after ackDelay idle cycles; strayAck pulses ack while idle.
    int ackDelay = 0;
    bit strayAck = 1'b0;
    initial begin
        int waitCnt;
        bit heldReq;
        logic [ADDR_W-1:0] holdAddr;
        logic holdWe;
        waitCnt = 0;
        heldReq = 1'b0;
        holdAddr = '0;
        holdWe = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || !mem_req) begin
                mem_ack = strayAck && !rst;
                mem_rdata = $urandom;
                waitCnt = 0;
                heldReq = 1'b0;
            end else begin
                if (!mem_ack && heldReq)
                    check("memHold", 256'({holdWe, holdAddr}), 256'({mem_we, mem_addr}));
                if (mem_ack) waitCnt = 0;
                holdAddr = mem_addr;
                holdWe = mem_we;
                heldReq = 1'b1;
                if (waitCnt >= ackDelay) begin
                    mem_ack = 1'b1;
                    mem_rdata = extRd(mem_addr);
                    if (mem_we) extMem[mem_addr] = mem_wdata;
                end else begin
                    mem_ack = 1'b0;
                    mem_rdata = $urandom;
                    waitCnt++;
                end
            end
        end
    end

    int nDataW, nTagW, nMemW;
    logic [ADDR_W-1:0] rdAddrs [$];
    logic [ADDR_W-1:0] lastWAddr;
    logic [DATA_W-1:0] lastWData;
    initial begin
        nDataW = 0;
        nTagW = 0;
        nMemW = 0;
        lastWAddr = '0;
        lastWData = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (data_w_en) nDataW++;
                if (tag_w_en) nTagW++;
                if (mem_req && mem_ack) begin
                    if (mem_we) begin
                        nMemW++;
                        lastWAddr = mem_addr;
                        lastWData = mem_wdata;
                    end else rdAddrs.push_back(mem_addr);
                end
            end
        end
    end

    function automatic logic [255:0] allOuts();
        return 256'({cpu_ready, cpu_rdata, tag_index, tag_in, tag_w_en, data_index, data_word,
                     data_w_en, data_wdata, mem_req, mem_we, mem_addr, mem_wdata});
    endfunction

    task automatic clearModel();
        for (int i = 0; i < CACHE_LINE_NUM; i++) mVal[i] = 1'b0;
    endtask

    // One CPU access, called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic doAccess(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
        logic [INDEX_LENGTH-1:0] idx;
        logic [TAG_LENGTH-1:0] tg;
        logic [DATA_W-1:0] rdata;
        bit expHit;
        bit seen;
        int cyc;
        idx = addr[OFF_W +: INDEX_LENGTH];
        tg = addr[ADDR_W-1 -: TAG_LENGTH];
        expHit = mVal[idx] && (mTag[idx] == tg);
        nDataW = 0;
        nTagW = 0;
        nMemW = 0;
        rdAddrs.delete();
        cpu_we = we;
        cpu_addr = addr;
        cpu_wdata = wdata;
        cpu_req = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!cpu_ready && cyc < 400);
        seen = cpu_ready;
        rdata = cpu_rdata;
        cpu_req = 1'b0;
        #1;
        check("readySeen", 256'(seen), 256'(1));
        if (!we) begin
            check("rdata", 256'(rdata), 256'(refRd(addr)));
            if (expHit) begin
                check("hitLat", 256'(cyc), 256'(1));
                check("hitMemRd", 256'(rdAddrs.size()), 256'(0));
                check("hitTagW", 256'(nTagW), 256'(0));
            end else begin
                check("missLat", 256'(cyc), 256'(2 + LINE_WORDS * (ackDelay + 1)));
                check("missMemRd", 256'(rdAddrs.size()), 256'(LINE_WORDS));
                if (rdAddrs.size() == LINE_WORDS)
                    for (int i = 0; i < LINE_WORDS; i++)
                        check("refillAddr", 256'(rdAddrs[i]), 256'({addr[ADDR_W-1:OFF_W], WORD_W'(i), 2'b00}));
                check("missTagW", 256'(nTagW), 256'(1));
                check("missDataW", 256'(nDataW), 256'(LINE_WORDS));
                mVal[idx] = 1'b1;
                mTag[idx] = tg;
            end
        end else begin
            check("wLat", 256'(cyc), 256'(1 + ackDelay + 1));
            check("wMemCnt", 256'(nMemW), 256'(1));
            check("wAddr", 256'(lastWAddr), 256'(addr));
            check("wData", 256'(lastWData), 256'(wdata));
            check("wDataW", 256'(nDataW), 256'(expHit));
            check("wTagW", 256'(nTagW), 256'(0));
            check("wNoRd", 256'(rdAddrs.size()), 256'(0));
            refMem[addr] = wdata;
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        cpu_addr = '0;
        cpu_wdata = '0;
        clearModel();
        #1;
        check("rstOuts", allOuts(), 256'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("postRstOuts", allOuts(), 256'(0));
        @(negedge clk);

        doAccess(1'b0, 32'h0000_0000, '0);
        doAccess(1'b0, 32'h0000_0008, '0);
        doAccess(1'b0, 32'h0000_0400, '0);
        doAccess(1'b0, 32'h0000_0000, '0);
        doAccess(1'b0, 32'h0000_0400, '0);
        doAccess(1'b0, 32'h0000_0000, '0);
        doAccess(1'b1, 32'h0000_0004, 32'hDEAD_BEEF);
        doAccess(1'b0, 32'h0000_0004, '0);
        doAccess(1'b1, 32'h0000_2000, 32'h1234_5678);
        doAccess(1'b0, 32'h0000_0004, '0);
        doAccess(1'b0, 32'h0000_2000, '0);

        strayAck = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("strayIdle", 256'({cpu_ready, data_w_en, tag_w_en, mem_req}), 256'(0));
        end
        strayAck = 1'b0;
        @(negedge clk);

        ackDelay = 5;
        doAccess(1'b0, 32'h0000_0044, '0);
        doAccess(1'b1, 32'h0000_0048, 32'hCAFE_F00D);
        doAccess(1'b0, 32'h0000_0048, '0);
        ackDelay = 0;

        // Reset lands after the second refill word has been written.
        rdAddrs.delete();
        cpu_we = 1'b0;
        cpu_addr = 32'h0000_0080;
        cpu_req = 1'b1;
        cyc = 0;
        while (rdAddrs.size() < 2 && cyc < 100) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("midRefillReached", 256'(rdAddrs.size()), 256'(2));
        @(posedge clk);
        #2;
        rst = 1'b1;
        cpu_req = 1'b0;
        #1;
        check("midRefillRst", allOuts(), 256'(0));
        clearModel();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        doAccess(1'b0, 32'h0000_0080, '0);
        doAccess(1'b0, 32'h0000_0000, '0);

        for (int n = 0; n < 150; n++) begin
            logic [ADDR_W-1:0] a;
            a = {TAG_LENGTH'($urandom_range(0, 2)), INDEX_LENGTH'($urandom_range(0, 3)),
                 WORD_W'($urandom_range(0, LINE_WORDS - 1)), 2'b00};
            ackDelay = $urandom_range(0, 3);
            strayAck = ($urandom_range(0, 3) == 0);
            doAccess($urandom_range(0, 9) < 3, a, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
